div_sched: RTL
==============

Name: div_sched

Overview:
Programmable clock-enable divider controller. It generates a one-cycle tick every N clk cycles and a square clk_out with a period of 2N cycles. The ratio N is loaded and changed at runtime through a valid/ready configuration port. Ratio changes and stop requests take effect only at a period boundary, so tick and clk_out never produce runt periods. It sits between the control/register logic and the downstream blocks that are clocked by enables.

Parameters:
CNT_W, 8, width of the ratio and counter; legal ratio range is 1..2^CNT_W-1.

Ports:
clk  input  1  system clock; all logic on posedge.
reset  input  1  synchronous, active-high reset.
cfg_valid  input  1  a new ratio is offered on cfg_div.
cfg_ready  output  1  the block can accept a configuration this cycle.
cfg_div  input  CNT_W  requested ratio N; 0 means stop.
resync  input  1  one-cycle pulse that restarts the period at count 0.
tick  output  1  registered, one-cycle enable pulse, once per period.
clk_out  output  1  registered square wave; toggles on every tick.
busy  output  1  high when the state is not IDLE.
state  output  2  IDLE=00, RUN=01, SWITCH=10.
cnt  output  CNT_W  current phase counter.

Behaviour:
- Reset values: state=IDLE, cnt=0, div_r=0, pend=0, tick=0, clk_out=0. cfg_ready=1 after reset. Reset mid-operation discards any pending configuration.
- Handshake: a configuration transfers at the clk edge where cfg_valid&cfg_ready=1. cfg_ready = (state!=SWITCH), decoded combinationally from state.
- IDLE:
  - Accepted N!=0: div_r<=N, cnt<=0, state<=RUN.
  - Accepted N=0: no-op, remain in IDLE.
  - tick=0, clk_out held at 0, cnt held at 0.
- RUN: every edge, cnt<=(cnt==div_r-1)?0:cnt+1.
  - Wrap edge (cnt==div_r-1): tick<=1 and clk_out<=~clk_out. On all other edges tick<=0.
  - Latency: for a handshake at edge T, the first tick is high in the cycle after edge T+N, then once every N cycles.
  - N=1: tick stays high continuously and clk_out toggles every cycle.
- Config accepted in RUN: pend<=cfg_div, state<=SWITCH. Counting continues at the old ratio.
- SWITCH: counting continues at div_r. At the next wrap edge, the tick/toggle for that wrap still occurs, and:
  - pend!=0: div_r<=pend, cnt<=0, state<=RUN.
  - pend=0: state<=IDLE, clk_out<=0, cnt<=0, and that final tick is still emitted.
  - A handshake and a wrap cannot coincide in SWITCH because cfg_ready=0.
- Config accepted on the same edge as a RUN wrap: the wrap tick occurs, then the state enters SWITCH. The new ratio applies at the following wrap, one full old period later.
- resync in RUN/SWITCH: cnt<=0, tick<=0, clk_out<=0.
  - resync has priority over a wrap on the same edge: no tick, no toggle.
  - In SWITCH, resync applies pend immediately (RUN with div_r=pend, or IDLE if pend=0).
  - resync in IDLE is ignored.
- Priority: reset > resync > wrap > handshake.
- Width rule: cnt never exceeds div_r-1; compares are unsigned at CNT_W. 2^CNT_W-1 is legal with no overflow.

Test Plan:
- Reset for 3 cycles, then cfg_div=4 handshake at edge T -> tick high after edges T+4, T+8, T+12; clk_out period 8 cycles; busy=1, state=01.
- Running N=4, offer cfg_div=2 at cnt=1 -> cfg_ready=0 until the next wrap; ticks at +4 (old period), then every 2 cycles; state 01->10->01.
- Running N=3, offer cfg_div=0 -> the current period completes with one final tick; then state=IDLE, clk_out=0, cnt=0, tick=0 thereafter.
- Running N=5, resync on the edge where cnt=4 -> no tick that cycle, cnt=0, clk_out=0; the next tick comes 5 cycles later.
- cfg_div=1 from IDLE -> tick continuously high and clk_out toggles every cycle. Then apply reset mid-run -> all outputs 0 next cycle, cfg_ready=1.
- cfg_div=255 (CNT_W=8) -> cnt reaches 254 then wraps to 0 with a tick; period 255; no overflow.

Source files
------------

// File: rtl/div_sched.sv
// Programmable clock-enable divider: one-cycle tick every N cycles plus a 2N-cycle square wave,
// with ratio changes and stops deferred to a period boundary so no runt periods are produced.
module div_sched #(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_div,
   input  logic             resync,
   output logic             tick,
   output logic             clk_out,
   output logic             busy,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      SWITCH = 2'b10
   } state_t;

   state_t           state_r;
   logic [CNT_W-1:0] div_r;
   logic [CNT_W-1:0] pend;
   logic             wrap;
   logic             cfg_fire;

   // div_r is never zero outside IDLE, so the subtraction cannot underflow where it matters
   assign wrap      = (cnt == (div_r - CNT_W'(1)));
   assign cfg_ready = (state_r != SWITCH);
   assign cfg_fire  = cfg_valid & cfg_ready;
   assign busy      = (state_r != IDLE);
   assign state     = state_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
         cnt     <= '0;
         div_r   <= '0;
         pend    <= '0;
         tick    <= 1'b0;
         clk_out <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               tick    <= 1'b0;
               clk_out <= 1'b0;
               cnt     <= '0;
               if (cfg_fire && (cfg_div != '0)) begin
                  div_r   <= cfg_div;
                  state_r <= RUN;
               end
            end

            RUN: begin
               if (resync) begin
                  cnt     <= '0;
                  tick    <= 1'b0;
                  clk_out <= 1'b0;
               end else if (wrap) begin
                  cnt     <= '0;
                  tick    <= 1'b1;
                  clk_out <= ~clk_out;
               end else begin
                  cnt  <= cnt + CNT_W'(1);
                  tick <= 1'b0;
               end
               // New ratio is held until the next period boundary
               if (cfg_fire) begin
                  pend    <= cfg_div;
                  state_r <= SWITCH;
               end
            end

            SWITCH: begin
               if (resync) begin
                  cnt     <= '0;
                  tick    <= 1'b0;
                  clk_out <= 1'b0;
                  if (pend != '0) begin
                     div_r   <= pend;
                     state_r <= RUN;
                  end else begin
                     state_r <= IDLE;
                  end
               end else if (wrap) begin
                  cnt  <= '0;
                  tick <= 1'b1;
                  if (pend != '0) begin
                     clk_out <= ~clk_out;
                     div_r   <= pend;
                     state_r <= RUN;
                  end else begin
                     clk_out <= 1'b0;
                     state_r <= IDLE;
                  end
               end else begin
                  cnt  <= cnt + CNT_W'(1);
                  tick <= 1'b0;
               end
            end

            default: begin
               state_r <= IDLE;
               cnt     <= '0;
               tick    <= 1'b0;
               clk_out <= 1'b0;
            end
         endcase
      end
   end

endmodule
